// File: rtl/fetch_buffer_if.sv
// Fetch/decode handshake bundle for fetch_buffer. The buffer attaches through the
// slave modport; the fetch/decode side (or a bench) drives through the master modport.
interface fetch_buffer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            flush_i;
    logic            fetch_valid_i;
    logic [31:0]     fetch_instr_i;
    logic [31:0]     fetch_address_i;
    logic            fetch_fault_i;
    logic            fetch_ready_o;
    logic            decode_ready_i;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [31:0]     instr_address_o;
    logic            instr_fault_o;
    logic [CntW-1:0] count_o;

    modport master (
        output flush_i, fetch_valid_i, fetch_instr_i, fetch_address_i, fetch_fault_i,
               decode_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_o, instr_address_o, instr_fault_o, count_o
    );

    modport slave (
        input  flush_i, fetch_valid_i, fetch_instr_i, fetch_address_i, fetch_fault_i,
               decode_ready_i,
        output fetch_ready_o, instr_valid_o, instr_o, instr_address_o, instr_fault_o, count_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction FIFO between fetch and decode; flushable, never presents X to decode.
// Optional zero-latency empty-buffer bypass enabled by FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input logic           clk_i,
    input logic           rst_i,
    fetch_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] Nop  = 32'h0000_0013;

    typedef struct packed {
        logic        fault;
        logic [31:0] address;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, bypass, push, pop;
    entry_t          wr_entry, head;

    always_comb begin
        full  = (count_q == CntW'(DEPTH));
        empty = (count_q == '0);
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass = empty & bus.fetch_valid_i & ~bus.flush_i;
`else
        bypass = 1'b0;
`endif
        // A bypassed instruction the decoder takes immediately is never stored.
        push = bus.fetch_valid_i & ~full & ~bus.flush_i & ~(bypass & bus.decode_ready_i);
        pop  = ~empty & bus.decode_ready_i & ~bus.flush_i;

        wr_entry.fault   = bus.fetch_fault_i;
        wr_entry.address = bus.fetch_address_i;
        wr_entry.instr   = bus.fetch_instr_i;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is intentionally not reset; empty-state outputs are masked below.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wr_entry;
    end

    always_comb begin
        head.fault   = 1'b0;
        head.address = '0;
        head.instr   = Nop;
        if (!empty) begin
            head = mem_q[rptr_q];
        end else if (bypass) begin
            head = wr_entry;
        end

        bus.fetch_ready_o   = ~full;
        bus.instr_valid_o   = ~empty | bypass;
        bus.instr_fault_o   = head.fault;
        bus.instr_address_o = head.address;
        bus.instr_o         = head.fault ? Nop : head.instr;
        bus.count_o         = count_q;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scoreboard bench for fetch_buffer; expected entries are queued on accepted pushes
// and compared at the head when the decoder consumes them.
module tb_fetch_buffer;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic        fault;
        logic [31:0] address;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input exp_t e);
        chk({tag, "_instr"}, bus.instr_o, e.instr);
        chk({tag, "_addr"}, bus.instr_address_o, e.address);
        chk({tag, "_fault"}, {31'b0, bus.instr_fault_o}, {31'b0, e.fault});
    endtask

    // One clock of stimulus: drive, check visible state against the model, update the model.
    task automatic cycle(input logic fv, input logic [31:0] ins, input logic [31:0] adr,
                         input logic flt, input logic dr, input logic fl);
        bit   byp;
        bit   accept;
        exp_t e;
        exp_t idle;
        bus.fetch_valid_i   = fv;
        bus.fetch_instr_i   = ins;
        bus.fetch_address_i = adr;
        bus.fetch_fault_i   = flt;
        bus.decode_ready_i  = dr;
        bus.flush_i         = fl;
        #1;
        byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        byp = (sb.size() == 0) && fv && !fl;
`endif
        e.fault      = flt;
        e.address    = adr;
        e.instr      = flt ? NOP : ins;
        idle.fault   = 1'b0;
        idle.address = '0;
        idle.instr   = NOP;
        chk("count", {28'b0, bus.count_o}, sb.size());
        chk("fetch_ready", {31'b0, bus.fetch_ready_o}, {31'b0, sb.size() != DEPTH});
        chk("instr_valid", {31'b0, bus.instr_valid_o}, {31'b0, (sb.size() != 0) || byp});
        if (byp) chk_head("bypass", e);
        else if (sb.size() == 0) chk_head("empty", idle);
        accept = fv && !fl && (sb.size() != DEPTH) && !(byp && dr);
        if (fl) begin
            sb.delete();
        end else begin
            if (dr && sb.size() != 0) begin
                chk_head("pop", sb[0]);
                void'(sb.pop_front());
            end
            if (accept) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic dr);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, dr, 1'b0);
    endtask

    initial begin
        exp_t h;
        rst                 = 1'b1;
        bus.flush_i         = 1'b0;
        bus.fetch_valid_i   = 1'b0;
        bus.fetch_instr_i   = '0;
        bus.fetch_address_i = '0;
        bus.fetch_fault_i   = 1'b0;
        bus.decode_ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        idle_cycle(1'b0);

        // Single push, visible one cycle later.
        cycle(1'b1, 32'h0050_0093, 32'h1000, 1'b0, 1'b0, 1'b0);
        h.fault = 1'b0; h.address = 32'h1000; h.instr = 32'h0050_0093;
        chk_head("first", h);
        chk("first_valid", {31'b0, bus.instr_valid_o}, 32'd1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Fill to full, refuse a 9th, then push+pop while full.
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + i, 32'h1000 + 4 * i, 1'b0, 1'b0, 1'b0);
        chk("full_count", {28'b0, bus.count_o}, 32'd8);
        chk("full_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
        cycle(1'b1, 32'h999, 32'h9000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h999, 32'h9000, 1'b0, 1'b1, 1'b0);
        chk("after_full_pop_count", {28'b0, bus.count_o}, 32'd7);
        chk("after_full_pop_ready", {31'b0, bus.fetch_ready_o}, 32'd1);
        repeat (8) idle_cycle(1'b1);

        // Steady push/pop at occupancy 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + i, 32'h1000 + 4 * i, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 23; i++) begin
            cycle(1'b1, 32'h200 + i, 32'h1000 + 4 * i, 1'b0, 1'b1, 1'b0);
            chk("steady_count", {28'b0, bus.count_o}, 32'd3);
        end
        repeat (4) idle_cycle(1'b1);

        // Flush with five held and a concurrent push and pop request.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + i, 32'h4000 + 4 * i, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h3FF, 32'h4FFC, 1'b0, 1'b1, 1'b1);
        chk("flush_count", {28'b0, bus.count_o}, 32'd0);
        chk("flush_valid", {31'b0, bus.instr_valid_o}, 32'd0);
        chk("flush_instr", bus.instr_o, NOP);
        chk("flush_ready", {31'b0, bus.fetch_ready_o}, 32'd1);
        idle_cycle(1'b1);

        // Faulting fetch: instruction forced to NOP, address preserved.
        cycle(1'b1, 32'hDEAD_BEEF, 32'h2000, 1'b1, 1'b0, 1'b0);
        h.fault = 1'b1; h.address = 32'h2000; h.instr = NOP;
        chk_head("fault", h);
        idle_cycle(1'b1);

        // Empty buffer, push with decoder ready (zero-latency when bypass is built in).
        cycle(1'b1, 32'h00A0_0113, 32'h3000, 1'b0, 1'b1, 1'b0);
        repeat (2) idle_cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
